// File: rtl/data_sram_responder.sv
// Responder end of the sram-like data port. Accepts req/addr_ok handshakes,
// commits stores into on-chip word memory, and answers every request in
// order with data_ok/rdata after a fixed latency. Up to FIFO_DEPTH requests
// can be outstanding; each FIFO entry carries its own latency countdown.
module data_sram_responder #(
  parameter int MEM_AW     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        stall,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [2:0]  outstanding,
  output logic        align_err
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int LW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNTW-1:0] DEPTH    = CNTW'(FIFO_DEPTH);
  localparam logic [LW-1:0]   LOAD_CNT = LW'(LATENCY - 1);

  logic [31:0] mem [0:(1 << MEM_AW) - 1];

  logic [FIFO_DEPTH-1:0] ent_valid;
  logic [FIFO_DEPTH-1:0] ent_wr;
  logic [31:0]           ent_data [FIFO_DEPTH];
  logic [LW-1:0]         ent_cnt  [FIFO_DEPTH];

  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CNTW-1:0] count;

  logic [MEM_AW-1:0] word_idx;
  logic              accept;
  logic              pop;
  logic              misaligned;
  logic              unused_addr_hi;

  // Only the word index bits select memory; the rest of the address is ignored.
  assign word_idx       = data_sram_addr[MEM_AW+1:2];
  assign unused_addr_hi = ^data_sram_addr[31:MEM_AW+2];

  // A slot must be free before the edge; a pop at the same edge does not count.
  assign data_sram_addr_ok = data_sram_req & ~stall & (count < DEPTH);
  assign accept            = data_sram_req & data_sram_addr_ok;

  // The response comes purely from registered head state.
  assign data_sram_data_ok = ent_valid[head] & (ent_cnt[head] == '0);
  assign pop               = data_sram_data_ok;
  assign data_sram_rdata   = (data_sram_data_ok && !ent_wr[head]) ? ent_data[head] : 32'h0;
  assign outstanding       = 3'(count);

  // Flag accesses whose size does not match the low address bits.
  always_comb begin
    misaligned = 1'b0;
    case (data_sram_size)
      2'b01:   misaligned = data_sram_addr[0];
      2'b10:   misaligned = (data_sram_addr[1:0] != 2'b00);
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Byte-lane store commit; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) begin
          mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response FIFO: countdown every live entry, push on accept, pop on data_ok.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid <= '0;
      ent_wr    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_data[i] <= '0;
        ent_cnt[i]  <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (ent_valid[i] && ent_cnt[i] != '0) begin
          ent_cnt[i] <= ent_cnt[i] - 1'b1;
        end
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      if (accept) begin
        ent_valid[tail] <= 1'b1;
        ent_wr[tail]    <= data_sram_wr;
        ent_data[tail]  <= data_sram_wr ? 32'h0 : mem[word_idx];
        ent_cnt[tail]   <= LOAD_CNT;
        tail            <= tail + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      align_err <= 1'b0;
    end else if (accept && misaligned) begin
      align_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder. The main instance runs with
// LATENCY=2; a second instance with LATENCY=6 keeps enough requests in
// flight to fill the FIFO and to hold three outstanding across a reset.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        req_deep;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;

  logic        addr_ok, data_ok, align_err;
  logic [31:0] rdata;
  logic [2:0]  outstanding;
  logic        addr_ok_deep, data_ok_deep, align_err_deep;
  logic [31:0] rdata_deep;
  logic [2:0]  outstanding_deep;

  int checks   = 0;
  int failures = 0;
  int n;

  // Expected per-cycle behaviour of the deep instance while req is held for 5 loads.
  bit          exp_aok [15] = '{1,1,1,1,0,0,0,1,0,0,0,0,0,0,0};
  bit          exp_dok [15] = '{0,0,0,0,0,0,1,1,1,1,0,0,0,1,0};
  int          exp_out [15] = '{0,1,2,3,4,4,4,3,3,2,1,1,1,1,0};
  logic [31:0] exp_rd  [15] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003,
                                32'h0, 32'h0, 32'h0, 32'h10000000, 32'h0};

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  data_sram_responder #(.MEM_AW(12), .FIFO_DEPTH(4), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
    .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .stall(stall),
    .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata), .outstanding(outstanding), .align_err(align_err)
  );

  data_sram_responder #(.MEM_AW(12), .FIFO_DEPTH(4), .LATENCY(6)) dut_deep (
    .clk(clk), .reset(reset),
    .data_sram_req(req_deep), .data_sram_wr(wr), .data_sram_size(size),
    .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .stall(stall),
    .data_sram_addr_ok(addr_ok_deep), .data_sram_data_ok(data_ok_deep),
    .data_sram_rdata(rdata_deep), .outstanding(outstanding_deep),
    .align_err(align_err_deep)
  );

  task automatic applyStimulus(input logic r, input logic rd, input logic w,
                               input logic [1:0] sz, input logic [3:0] ws,
                               input logic [31:0] a, input logic [31:0] wd);
    req      = r;
    req_deep = rd;
    wr       = w;
    size     = sz;
    wstrb    = ws;
    addr     = a;
    wdata    = wd;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    idle();
    tick();
    checkOutput("rst_data_ok", 32'(data_ok), 32'd0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
    checkOutput("rst_align_err", 32'(align_err), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("idle_addr_ok", 32'(addr_ok), 32'd0);

    $display("[TB] full-word store, then load with pop and push on one edge");
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 4'hF, 32'h10, 32'hAABBCCDD);
    checkOutput("t1_store_addr_ok", 32'(addr_ok), 32'd1);
    tick();
    idle();
    checkOutput("t1_early_data_ok", 32'(data_ok), 32'd0);
    checkOutput("t1_outstanding1", 32'(outstanding), 32'd1);
    tick();
    checkOutput("t1_store_data_ok", 32'(data_ok), 32'd1);
    checkOutput("t1_store_rdata", rdata, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 4'h0, 32'h10, 32'h0);
    checkOutput("t1_load_addr_ok", 32'(addr_ok), 32'd1);
    tick();
    idle();
    checkOutput("t1_pushpop_count", 32'(outstanding), 32'd1);
    checkOutput("t1_gap_data_ok", 32'(data_ok), 32'd0);
    tick();
    checkOutput("t1_load_data_ok", 32'(data_ok), 32'd1);
    checkOutput("t1_load_rdata", rdata, 32'hAABBCCDD);
    tick();
    checkOutput("t1_drained", 32'(outstanding), 32'd0);
    checkOutput("t1_quiet", 32'(data_ok), 32'd0);

    $display("[TB] single-lane store and empty-strobe store");
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 4'b0100, 32'h10, 32'h00EE0000);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 4'h0, 32'h10, 32'h0);
    tick();
    idle();
    checkOutput("t2_store_data_ok", 32'(data_ok), 32'd1);
    checkOutput("t2_store_rdata", rdata, 32'h0);
    tick();
    checkOutput("t2_load_data_ok", 32'(data_ok), 32'd1);
    checkOutput("t2_load_rdata", rdata, 32'hAAEECCDD);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 4'h0, 32'h10, 32'hFFFFFFFF);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 4'h0, 32'h10, 32'h0);
    tick();
    idle();
    checkOutput("t2_nostrb_data_ok", 32'(data_ok), 32'd1);
    checkOutput("t2_nostrb_rdata", rdata, 32'h0);
    tick();
    checkOutput("t2_nostrb_load", rdata, 32'hAAEECCDD);
    tick();

    $display("[TB] FIFO fill on the deep instance");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 2'b10, 4'hF, 32'(32'h20 + 4 * i), 32'(32'h10000000 + i));
      tick();
    end
    idle();
    repeat (8) tick();
    checkOutput("t3_pre_out", 32'(outstanding), 32'd0);
    checkOutput("t3_pre_out_deep", 32'(outstanding_deep), 32'd0);
    n = 0;
    for (int c = 0; c < 15; c++) begin
      applyStimulus(1'b0, (n < 5), 1'b0, 2'b10, 4'h0, 32'(32'h20 + 4 * (n % 4)), 32'h0);
      checkOutput($sformatf("t3_addr_ok_c%0d", c), 32'(addr_ok_deep), 32'(exp_aok[c]));
      checkOutput($sformatf("t3_data_ok_c%0d", c), 32'(data_ok_deep), 32'(exp_dok[c]));
      checkOutput($sformatf("t3_rdata_c%0d", c), rdata_deep, exp_rd[c]);
      checkOutput($sformatf("t3_out_c%0d", c), 32'(outstanding_deep), 32'(exp_out[c]));
      if (req_deep && addr_ok_deep) n++;
      tick();
    end
    idle();

    $display("[TB] stall backpressure");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 4'h0, 32'h10, 32'h0);
      checkOutput("t4_stall_addr_ok", 32'(addr_ok), 32'd0);
      checkOutput("t4_stall_out", 32'(outstanding), 32'd0);
      tick();
    end
    stall = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 4'h0, 32'h10, 32'h0);
    checkOutput("t4_release_addr_ok", 32'(addr_ok), 32'd1);
    tick();
    idle();
    checkOutput("t4_accepted", 32'(outstanding), 32'd1);
    tick();
    checkOutput("t4_data_ok", 32'(data_ok), 32'd1);
    checkOutput("t4_rdata", rdata, 32'hAAEECCDD);
    tick();

    $display("[TB] misaligned word load");
    checkOutput("t5_align_before", 32'(align_err), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 4'h0, 32'h12, 32'h0);
    tick();
    idle();
    checkOutput("t5_align_set", 32'(align_err), 32'd1);
    tick();
    checkOutput("t5_data_ok", 32'(data_ok), 32'd1);
    checkOutput("t5_rdata", rdata, 32'hAAEECCDD);
    repeat (3) tick();
    checkOutput("t5_align_sticky", 32'(align_err), 32'd1);

    $display("[TB] reset with three requests in flight");
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, (c < 3), 1'b0, 2'b10, 4'h0, 32'(32'h20 + 4 * c), 32'h0);
      tick();
    end
    checkOutput("t6_pre_data_ok", 32'(data_ok_deep), 32'd1);
    checkOutput("t6_pre_rdata", rdata_deep, 32'h10000000);
    checkOutput("t6_pre_out", 32'(outstanding_deep), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_data_ok", 32'(data_ok_deep), 32'd0);
    checkOutput("t6_rst_out", 32'(outstanding_deep), 32'd0);
    checkOutput("t6_rst_rdata", rdata_deep, 32'h0);
    checkOutput("t6_rst_align", 32'(align_err), 32'd0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("t6_no_data_ok_deep", 32'(data_ok_deep), 32'd0);
      checkOutput("t6_no_data_ok", 32'(data_ok), 32'd0);
    end
    checkOutput("t6_post_out", 32'(outstanding_deep), 32'd0);

    $display("[TB] half-word and size=11 alignment boundaries");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b01, 4'h0, 32'h12, 32'h0);
    tick();
    idle();
    checkOutput("t7_half_aligned", 32'(align_err), 32'd0);
    tick();
    checkOutput("t7_half_rdata", rdata, 32'hAAEECCDD);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b01, 4'h0, 32'h11, 32'h0);
    tick();
    idle();
    checkOutput("t7_half_odd", 32'(align_err), 32'd1);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    checkOutput("t7_cleared", 32'(align_err), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 4'h0, 32'h10, 32'h0);
    tick();
    idle();
    checkOutput("t7_size11", 32'(align_err), 32'd1);
    tick();
    checkOutput("t7_size11_rdata", rdata, 32'hAAEECCDD);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
